// File: rtl/alarm_controller.sv
// alarm_controller: alarm-time registers, 1 Hz timebase, tone divider and the
// ring/snooze/timeout state machine driving the buzzer of the 24-h BCD clock.
// Optional build macro ALARM_HOURLY_CHIME_EN adds a one-second tone at the top
// of every hour while the alarm is armed and idle.
module alarm_controller #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TONE_HZ        = 2000,
  parameter int SNOOZE_S       = 300,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic       MAX10_CLK1_50,
  input  logic       RESET_N,
  input  logic [3:0] HOUR_TEN,
  input  logic [3:0] HOUR_ONE,
  input  logic [3:0] MIN_TEN,
  input  logic [3:0] MIN_ONE,
  input  logic [3:0] SEC_TEN,
  input  logic [3:0] SEC_ONE,
  input  logic [7:0] SET_IN,
  input  logic       LOAD_HOUR,
  input  logic       LOAD_MIN,
  input  logic       ALARM_EN,
  input  logic       SNOOZE,
  input  logic       STOP,
  output logic [7:0] A_HOUR,
  output logic [7:0] A_MIN,
  output logic       BUZZER,
  output logic       RINGING,
  output logic       SNOOZING
);

  localparam int SEC_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int TONE_DIV = (CLK_HZ / (2 * TONE_HZ) > 0) ? CLK_HZ / (2 * TONE_HZ) : 1;
  localparam int TONE_W   = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam int RING_W   = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1;
  localparam int SNZ_W    = (SNOOZE_S > 1) ? $clog2(SNOOZE_S) : 1;

  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(CLK_HZ - 1);
  localparam logic [SEC_W-1:0]  SEC_HALF  = SEC_W'(CLK_HZ / 2);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT_S - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_S - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  // Hour value is a legal 24-h BCD hour: 00..23.
  function automatic logic hour_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= 8'h23);
  endfunction

  // Minute value is a legal BCD minute: 00..59.
  function automatic logic min_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  logic [7:0]        a_hour_q, a_hour_d;
  logic [7:0]        a_min_q, a_min_d;
  logic [SEC_W-1:0]  sec_cnt_q, sec_cnt_d;
  logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
  logic              tone_q, tone_d;
  state_t            state_q, state_d;
  logic [RING_W-1:0] ring_s_q, ring_s_d;
  logic [SNZ_W-1:0]  snz_s_q, snz_s_d;
  logic              fired_q, fired_d;
  logic              ringing_q, ringing_d;
  logic              snoozing_q, snoozing_d;

  logic tick;
  logic half;
  logic hm_eq;
  logic sec_zero;
  logic match;
  logic trigger;
  logic ring_buzz;

  assign tick      = (sec_cnt_q == SEC_LAST);
  assign half      = (sec_cnt_q < SEC_HALF);
  assign hm_eq     = ({HOUR_TEN, HOUR_ONE, MIN_TEN, MIN_ONE} == {a_hour_q, a_min_q});
  assign sec_zero  = (SEC_TEN == 4'd0) && (SEC_ONE == 4'd0);
  assign match     = ALARM_EN && hm_eq && sec_zero;
  // Only the first matching cycle of the alarm minute may start a ring.
  assign trigger   = match && !fired_q;
  assign ring_buzz = (state_q == ST_RING) && tone_q && half;

  // Alarm-time registers: accept only legal BCD values, otherwise hold.
  always_comb begin
    a_hour_d = a_hour_q;
    a_min_d  = a_min_q;
    if (LOAD_HOUR && hour_ok(SET_IN)) a_hour_d = SET_IN;
    if (LOAD_MIN && min_ok(SET_IN))   a_min_d  = SET_IN;
  end

  // Free-running one-second counter and tone square-wave divider.
  always_comb begin
    sec_cnt_d  = tick ? '0 : sec_cnt_q + SEC_W'(1);
    tone_cnt_d = tone_cnt_q + TONE_W'(1);
    tone_d     = tone_q;
    if (tone_cnt_q == TONE_LAST) begin
      tone_cnt_d = '0;
      tone_d     = !tone_q;
    end
  end

  // Fired flag: set on a match, released once the time leaves the alarm minute.
  always_comb begin
    fired_d = fired_q;
    if (!hm_eq)     fired_d = 1'b0;
    else if (match) fired_d = 1'b1;
  end

  // Ring/snooze/timeout state machine; disarming overrides every state.
  always_comb begin
    state_d  = state_q;
    ring_s_d = ring_s_q;
    snz_s_d  = snz_s_q;
    if (!ALARM_EN) begin
      state_d  = ST_IDLE;
      ring_s_d = '0;
      snz_s_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_d  = ST_RING;
            ring_s_d = '0;
          end
        end
        ST_RING: begin
          if (STOP) begin
            state_d = ST_IDLE;
          end else if (SNOOZE) begin
            state_d = ST_SNOOZE;
            snz_s_d = '0;
          end else if (tick) begin
            if (ring_s_q == RING_LAST) state_d = ST_IDLE;
            else                       ring_s_d = ring_s_q + RING_W'(1);
          end
        end
        ST_SNOOZE: begin
          if (STOP) begin
            state_d = ST_IDLE;
          end else if (tick) begin
            if (snz_s_q == SNZ_LAST) begin
              state_d  = ST_RING;
              ring_s_d = '0;
            end else begin
              snz_s_d = snz_s_q + SNZ_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Status outputs are registered decodes of the next state.
  always_comb begin
    ringing_d  = (state_d == ST_RING);
    snoozing_d = (state_d == ST_SNOOZE);
  end

  // State, timebase and alarm registers with synchronous active-low reset.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (!RESET_N) begin
      a_hour_q   <= 8'h06;
      a_min_q    <= 8'h30;
      sec_cnt_q  <= '0;
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
      state_q    <= ST_IDLE;
      ring_s_q   <= '0;
      snz_s_q    <= '0;
      fired_q    <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      a_hour_q   <= a_hour_d;
      a_min_q    <= a_min_d;
      sec_cnt_q  <= sec_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
      state_q    <= state_d;
      ring_s_q   <= ring_s_d;
      snz_s_q    <= snz_s_d;
      fired_q    <= fired_d;
      ringing_q  <= ringing_d;
      snoozing_q <= snoozing_d;
    end
  end

`ifdef ALARM_HOURLY_CHIME_EN
  logic             chime_act_q, chime_act_d;
  logic             chime_done_q, chime_done_d;
  logic [SEC_W-1:0] chime_cnt_q, chime_cnt_d;
  logic             top_of_hour;

  assign top_of_hour = (MIN_TEN == 4'd0) && (MIN_ONE == 4'd0) && sec_zero;

  // Hourly chime: one tick period of plain tone, cancelled by any ring activity.
  always_comb begin
    chime_act_d  = chime_act_q;
    chime_cnt_d  = chime_cnt_q;
    chime_done_d = chime_done_q;
    if (!top_of_hour) chime_done_d = 1'b0;
    if (chime_act_q) begin
      if (chime_cnt_q == SEC_LAST) begin
        chime_act_d = 1'b0;
        chime_cnt_d = '0;
      end else begin
        chime_cnt_d = chime_cnt_q + SEC_W'(1);
      end
    end
    if ((state_q == ST_IDLE) && ALARM_EN && top_of_hour && !chime_done_q) begin
      chime_done_d = 1'b1;
      if (!trigger) begin
        chime_act_d = 1'b1;
        chime_cnt_d = '0;
      end
    end
    if (!ALARM_EN || (state_d != ST_IDLE)) begin
      chime_act_d = 1'b0;
      chime_cnt_d = '0;
    end
  end

  // Chime registers with synchronous active-low reset.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (!RESET_N) begin
      chime_act_q  <= 1'b0;
      chime_done_q <= 1'b0;
      chime_cnt_q  <= '0;
    end else begin
      chime_act_q  <= chime_act_d;
      chime_done_q <= chime_done_d;
      chime_cnt_q  <= chime_cnt_d;
    end
  end

  assign BUZZER = ring_buzz || (chime_act_q && tone_q && (state_q == ST_IDLE));
`else
  assign BUZZER = ring_buzz;
`endif

  assign A_HOUR   = a_hour_q;
  assign A_MIN    = a_min_q;
  assign RINGING  = ringing_q;
  assign SNOOZING = snoozing_q;

endmodule
